park_space_tracker: RTL and testbench

- Maintains the 8-bit parking occupancy vector. Bit = 1 means the space is free; bit = 0 means it is occupied.
- On an accepted car entry, decodes the 3-bit space number and clears that bit. On an accepted car exit, decodes the number and sets that bit.
- Drives the entry-gate open timer.
- Its parking_capacity output feeds the space-number priority encoder, which returns the highest free space as enter_number.

---
 rtl/park_space_tracker.sv | 131 +++++++++++++
 tb/tb_park_space_tracker.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/park_space_tracker.sv
// Parking occupancy tracker: free-space vector, free count, entry gate timer.
// Entry requests go through a two-state gate FSM; exits are always evaluated.
module park_space_tracker #(
    parameter int GATE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enter_req,
    input  logic [2:0] enter_number,
    input  logic       exit_req,
    input  logic [2:0] exit_number,
    output logic [7:0] parking_capacity,
    output logic [3:0] free_count,
    output logic       full,
    output logic       empty,
    output logic       enter_ack,
    output logic       enter_err,
    output logic       exit_ack,
    output logic       exit_err,
    output logic       gate_open
);

    typedef enum logic {
        IDLE,
        GATE
    } state_t;

    localparam logic [3:0] TIMER_LOAD = 4'(GATE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] timer_q, timer_d;
    logic       gate_q, gate_d;
    logic [7:0] cap_q, cap_d;
    logic [3:0] cnt_q, cnt_d;
    logic       full_q, empty_q;
    logic       en_ack_q, en_err_q;
    logic       ex_ack_q, ex_err_q;
    logic       hold_en_q, hold_ex_q;

    logic       en_eval, en_acc, en_rej;
    logic       ex_eval, ex_acc, ex_rej;
    logic [7:0] en_oh, ex_oh;

    // All checks use the pre-edge vector, so a same-number entry/exit
    // pair can never both pass.
    always_comb begin
        en_oh   = 8'b1 << enter_number;
        ex_oh   = 8'b1 << exit_number;
        en_eval = (state_q == IDLE) && enter_req && !hold_en_q;
        en_acc  = en_eval && cap_q[enter_number];
        en_rej  = en_eval && !cap_q[enter_number];
        ex_eval = exit_req && !hold_ex_q;
        ex_acc  = ex_eval && !cap_q[exit_number];
        ex_rej  = ex_eval && cap_q[exit_number];
        cap_d   = (cap_q & ~(en_acc ? en_oh : 8'h00))
                | (ex_acc ? ex_oh : 8'h00);
        cnt_d   = cnt_q - 4'(en_acc) + 4'(ex_acc);
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        gate_d  = gate_q;
        unique case (state_q)
            IDLE: begin
                if (en_acc) begin
                    state_d = GATE;
                    timer_d = TIMER_LOAD;
                    gate_d  = 1'b1;
                end
            end
            GATE: begin
                if (timer_q == 4'd0) begin
                    state_d = IDLE;
                    gate_d  = 1'b0;
                end else begin
                    timer_d = timer_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gate_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            timer_q   <= 4'd0;
            gate_q    <= 1'b0;
            cap_q     <= 8'hFF;
            cnt_q     <= 4'd8;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            en_ack_q  <= 1'b0;
            en_err_q  <= 1'b0;
            ex_ack_q  <= 1'b0;
            ex_err_q  <= 1'b0;
            hold_en_q <= 1'b0;
            hold_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            gate_q    <= gate_d;
            cap_q     <= cap_d;
            cnt_q     <= cnt_d;
            full_q    <= (cnt_d == 4'd0);
            empty_q   <= (cnt_d == 4'd8);
            en_ack_q  <= en_acc;
            en_err_q  <= en_rej;
            ex_ack_q  <= ex_acc;
            ex_err_q  <= ex_rej;
            // Skip one edge after a response so a slow requester
            // cannot be served twice.
            hold_en_q <= en_acc | en_rej;
            hold_ex_q <= ex_acc | ex_rej;
        end
    end

    assign parking_capacity = cap_q;
    assign free_count       = cnt_q;
    assign full             = full_q;
    assign empty            = empty_q;
    assign enter_ack        = en_ack_q;
    assign enter_err        = en_err_q;
    assign exit_ack         = ex_ack_q;
    assign exit_err         = ex_err_q;
    assign gate_open        = gate_q;

endmodule

// File: tb/tb_park_space_tracker.sv
// Directed bench for park_space_tracker.
// Inputs change 1 time unit after a rising edge; outputs are checked there too.
module tb_park_space_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       enter_req = 1'b0;
    logic [2:0] enter_number = 3'd0;
    logic       exit_req = 1'b0;
    logic [2:0] exit_number = 3'd0;
    logic [7:0] parking_capacity;
    logic [3:0] free_count;
    logic       full, empty;
    logic       enter_ack, enter_err;
    logic       exit_ack, exit_err;
    logic       gate_open;

    int checks = 0;
    int errors = 0;

    park_space_tracker #(.GATE_CYCLES(4)) dut (
        .clk(clk),
        .reset(reset),
        .enter_req(enter_req),
        .enter_number(enter_number),
        .exit_req(exit_req),
        .exit_number(exit_number),
        .parking_capacity(parking_capacity),
        .free_count(free_count),
        .full(full),
        .empty(empty),
        .enter_ack(enter_ack),
        .enter_err(enter_err),
        .exit_ack(exit_ack),
        .exit_err(exit_err),
        .gate_open(gate_open)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_pulses(input string tag, input logic ea,
                              input logic ee, input logic xa,
                              input logic xe);
        chk({tag, ".pulses"},
            {4'd0, enter_ack, enter_err, exit_ack, exit_err},
            {4'd0, ea, ee, xa, xe});
    endtask

    task automatic chk_state(input string tag, input logic [7:0] cap,
                             input logic [3:0] cnt, input logic fl,
                             input logic em);
        chk({tag, ".cap"}, parking_capacity, cap);
        chk({tag, ".cnt"}, {4'd0, free_count}, {4'd0, cnt});
        chk({tag, ".full_empty"}, {6'd0, full, empty}, {6'd0, fl, em});
    endtask

    initial begin
        // 1: asynchronous reset, observed before any clock edge
        #1 reset = 1'b1;
        #1;
        chk_state("rst", 8'hFF, 4'd8, 1'b0, 1'b1);
        chk("rst.gate", {7'd0, gate_open}, 8'd0);
        chk_pulses("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        tick();

        // 2: enter 7, then 6 held through the gate
        enter_req = 1'b1;
        enter_number = 3'd7;
        tick();
        chk_state("en7", 8'h7F, 4'd7, 1'b0, 1'b0);
        chk_pulses("en7", 1'b1, 1'b0, 1'b0, 1'b0);
        chk("en7.gate", {7'd0, gate_open}, 8'd1);
        enter_number = 3'd6;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("gate.hold", {7'd0, gate_open}, 8'd1);
            chk_pulses("gate.stall", 1'b0, 1'b0, 1'b0, 1'b0);
        end
        tick();
        chk("gate.close", {7'd0, gate_open}, 8'd0);
        chk("gate.cap", parking_capacity, 8'h7F);
        tick();
        chk_state("en6", 8'h3F, 4'd6, 1'b0, 1'b0);
        chk_pulses("en6", 1'b1, 1'b0, 1'b0, 1'b0);
        enter_req = 1'b0;
        tick();

        // 5: reset mid-gate
        chk("pre_rst.gate", {7'd0, gate_open}, 8'd1);
        reset = 1'b1;
        #1;
        chk_state("midrst", 8'hFF, 4'd8, 1'b0, 1'b1);
        chk("midrst.gate", {7'd0, gate_open}, 8'd0);
        tick();
        reset = 1'b0;
        tick();
        enter_req = 1'b1;
        enter_number = 3'd7;
        tick();
        chk_state("rst.en7", 8'h7F, 4'd7, 1'b0, 1'b0);
        chk_pulses("rst.en7", 1'b1, 1'b0, 1'b0, 1'b0);
        enter_req = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("rst.en7.close", {7'd0, gate_open}, 8'd0);

        // 3 and 6: occupied entry, held req, hold-off then re-evaluation
        enter_req = 1'b1;
        enter_number = 3'd7;
        tick();
        chk_pulses("err7", 1'b0, 1'b1, 1'b0, 1'b0);
        chk("err7.cap", parking_capacity, 8'h7F);
        tick();
        chk_pulses("err7.hold", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_pulses("err7.again", 1'b0, 1'b1, 1'b0, 1'b0);
        enter_req = 1'b0;
        tick();
        chk_pulses("err7.drop", 1'b0, 1'b0, 1'b0, 1'b0);
        exit_req = 1'b1;
        exit_number = 3'd2;
        tick();
        chk_pulses("xerr2", 1'b0, 1'b0, 1'b0, 1'b1);
        chk("xerr2.cap", parking_capacity, 8'h7F);
        exit_req = 1'b0;
        tick();

        // 6: exit ack with slow drop of req
        exit_req = 1'b1;
        exit_number = 3'd7;
        tick();
        chk_pulses("x7", 1'b0, 1'b0, 1'b1, 1'b0);
        chk_state("x7", 8'hFF, 4'd8, 1'b0, 1'b1);
        tick();
        chk_pulses("x7.hold", 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk_pulses("x7.again", 1'b0, 1'b0, 1'b0, 1'b1);
        exit_req = 1'b0;
        tick();

        // 4: fill all eight spaces from the top down
        for (int i = 7; i >= 0; i--) begin
            enter_req = 1'b1;
            enter_number = 3'(i);
            tick();
            chk_pulses("fill", 1'b1, 1'b0, 1'b0, 1'b0);
            chk("fill.cnt", {4'd0, free_count}, 8'(i));
            chk("fill.full", {7'd0, full}, {7'd0, (i == 0)});
            enter_req = 1'b0;
            for (int j = 0; j < 4; j++) tick();
        end
        chk_state("filled", 8'h00, 4'd0, 1'b1, 1'b0);

        // 4: simultaneous entry 0 / exit 5 on an empty-spaces vector
        enter_req = 1'b1;
        enter_number = 3'd0;
        exit_req = 1'b1;
        exit_number = 3'd5;
        tick();
        chk_pulses("sim", 1'b0, 1'b1, 1'b1, 1'b0);
        chk_state("sim", 8'h20, 4'd1, 1'b0, 1'b0);
        enter_req = 1'b0;
        exit_req = 1'b0;
        tick();

        // simultaneous different numbers: both apply, count unchanged
        enter_req = 1'b1;
        enter_number = 3'd5;
        exit_req = 1'b1;
        exit_number = 3'd3;
        tick();
        chk_pulses("both", 1'b1, 1'b0, 1'b1, 1'b0);
        chk_state("both", 8'h08, 4'd1, 1'b0, 1'b0);
        enter_req = 1'b0;
        exit_req = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
